// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter among NUM_REQ byte sources.
// A granted source keeps the transmitter until it sends a byte flagged last.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOW_WAIT_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 tx_ready,
    output logic [7:0]           tx_buff,
    output logic                 tx_start_trans,
    output logic                 busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOW_WAIT_MAX);
    localparam logic [CW-1:0] LOW_LAST = CW'(LOW_WAIT_MAX - 1);
    localparam logic [IW-1:0] REQ_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t               state, state_nxt;
    logic [7:0]           tx_buff_nxt;
    logic                 start_nxt;
    logic [NUM_REQ-1:0]   ready_nxt, grant_nxt;
    logic                 pkt_end, pkt_end_nxt;
    logic [IW-1:0]        rr_ptr, rr_nxt;
    logic [IW-1:0]        owner, owner_nxt;
    logic [CW-1:0]        low_cnt, low_nxt;
    logic [IW-1:0]        cand;
    logic                 cand_ok;

    // A locked owner is the only candidate; otherwise scan from rr_ptr, lowest offset wins.
    always_comb begin
        cand    = owner;
        cand_ok = 1'b0;
        if (grant != '0) begin
            cand_ok = req_valid[owner];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                automatic int idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (req_valid[idx]) begin
                    cand    = IW'(idx);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_buff_nxt = tx_buff;
        start_nxt   = 1'b0;
        ready_nxt   = '0;
        grant_nxt   = grant;
        pkt_end_nxt = pkt_end;
        rr_nxt      = rr_ptr;
        owner_nxt   = owner;
        low_nxt     = low_cnt;
        case (state)
            IDLE: begin
                if (cand_ok && tx_ready) begin
                    tx_buff_nxt     = req_data[int'(cand)*8 +: 8];
                    start_nxt       = 1'b1;
                    ready_nxt[cand] = 1'b1;
                    grant_nxt       = '0;
                    grant_nxt[cand] = 1'b1;
                    owner_nxt       = cand;
                    pkt_end_nxt     = req_last[cand];
                    low_nxt         = '0;
                    state_nxt       = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // Timeout guards against a transmitter that never acknowledges the start.
                if (!tx_ready || low_cnt == LOW_LAST) begin
                    low_nxt   = '0;
                    state_nxt = WAIT_HIGH;
                end else begin
                    low_nxt = low_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    state_nxt = IDLE;
                    if (pkt_end) begin
                        grant_nxt = '0;
                        rr_nxt    = (owner == REQ_LAST) ? '0 : owner + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tx_buff        <= '0;
            tx_start_trans <= 1'b0;
            req_ready      <= '0;
            grant          <= '0;
            pkt_end        <= 1'b0;
            rr_ptr         <= '0;
            owner          <= '0;
            low_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            tx_buff        <= tx_buff_nxt;
            tx_start_trans <= start_nxt;
            req_ready      <= ready_nxt;
            grant          <= grant_nxt;
            pkt_end        <= pkt_end_nxt;
            rr_ptr         <= rr_nxt;
            owner          <= owner_nxt;
            low_cnt        <= low_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, a simple UART model,
// and a start-pulse monitor that pops expected (requester, byte) pairs in order.
module tb_uart_tx_arbiter;
    localparam int NR       = 2;
    localparam int LWM      = 4;
    localparam int BYTE_LOW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [8*NR-1:0]   req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              tx_ready = 1'b1;
    logic [7:0]        tx_buff;
    logic              tx_start_trans;
    logic              busy;

    typedef struct { logic [7:0] d; logic last; } item_t;
    typedef struct { int id; logic [7:0] d; } exp_t;

    item_t     src_q[NR][$];
    exp_t      sb[$];
    int        start_t[$];
    logic [NR-1:0] active = '0;
    logic [NR-1:0] exp_oh;
    logic [7:0]    prev_buff = '0;
    int        checks = 0, errors = 0, cyc = 0, uart_cnt = 0;
    bit        uart_stuck = 0, uart_force_low = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .LOW_WAIT_MAX(LWM)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_ready(tx_ready),
        .tx_buff(tx_buff), .tx_start_trans(tx_start_trans), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor first, then UART model, then requester drivers, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            checks++;
            if ((req_ready & ~req_valid) != '0) begin
                errors++;
                $display("FAIL ready_without_valid: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            checks++;
            if (!tx_start_trans && tx_buff !== prev_buff) begin
                errors++;
                $display("FAIL buff_stable: tx_buff=%h expected held %h", tx_buff, prev_buff);
            end
            if (tx_start_trans) begin
                start_t.push_back(cyc);
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL overlap_start: start while tx_ready=%b, required 1", tx_ready);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: tx_buff=%h, no byte expected", tx_buff);
                end else begin
                    automatic exp_t e = sb.pop_front();
                    exp_oh = '0;
                    exp_oh[e.id] = 1'b1;
                    if (tx_buff !== e.d || grant !== exp_oh || req_ready !== exp_oh) begin
                        errors++;
                        $display("FAIL launch: buff=%h grant=%b rdy=%b, required buff=%h grant=%b rdy=%b",
                                 tx_buff, grant, req_ready, e.d, exp_oh, exp_oh);
                    end
                end
            end
        end
        prev_buff = tx_buff;

        if (uart_force_low) begin
            tx_ready = 1'b0;
        end else if (uart_stuck) begin
            tx_ready = 1'b1;
            uart_cnt = 0;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            tx_ready = (uart_cnt == 0);
        end else begin
            tx_ready = 1'b1;
        end
        if (rst_n && tx_start_trans && !uart_stuck && !uart_force_low) begin
            uart_cnt = BYTE_LOW;
            tx_ready = 1'b0;
        end

        for (int i = 0; i < NR; i++) begin
            if (!rst_n) begin
                active[i]    = 1'b0;
                req_valid[i] = 1'b0;
            end else begin
                if (active[i] && req_ready[i]) begin
                    active[i]    = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!active[i] && src_q[i].size() > 0) begin
                    automatic item_t it = src_q[i].pop_front();
                    req_data[i*8 +: 8] = it.d;
                    req_last[i]        = it.last;
                    req_valid[i]       = 1'b1;
                    active[i]          = 1'b1;
                end
            end
        end
    end

    task automatic send(input int id, input logic [7:0] d, input logic last);
        item_t it;
        exp_t  e;
        it.d = d; it.last = last;
        e.id = id; e.d = d;
        src_q[id].push_back(it);
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                active == '0 && !busy && tx_ready) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still pending, busy=%b, required 0 and idle", name, sb.size(), busy);
            sb.delete();
            src_q[0].delete();
            src_q[1].delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (tx_buff !== 8'h00)      begin errors++; $display("FAIL reset_buff: %h, required 00", tx_buff); end
        if (tx_start_trans !== 1'b0) begin errors++; $display("FAIL reset_start: %b, required 0", tx_start_trans); end
        if (req_ready !== '0)        begin errors++; $display("FAIL reset_ready: %b, required 00", req_ready); end
        if (grant !== '0)            begin errors++; $display("FAIL reset_grant: %b, required 00", grant); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(posedge clk); #1;
        send(0, 8'h41, 1'b1);
        @(negedge clk); #1;
        checks++;
        if (tx_start_trans !== 1'b0) begin errors++; $display("FAIL single_early: start=%b, required 0", tx_start_trans); end
        @(negedge clk); #1;
        checks++;
        if (tx_start_trans !== 1'b1 || tx_buff !== 8'h41) begin
            errors++;
            $display("FAIL single_latency: start=%b buff=%h, required 1 41", tx_start_trans, tx_buff);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b00 || tx_start_trans !== 1'b0 || grant !== 2'b01) begin
            errors++;
            $display("FAIL single_pulse: rdy=%b start=%b grant=%b, required 00 0 01", req_ready, tx_start_trans, grant);
        end
        wait_drain("single", 60);
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_release: grant=%b, required 00", grant); end
    endtask

    task automatic test_contention();
        apply_reset();
        @(posedge clk); #1;
        send(0, 8'h10, 1'b1); send(0, 8'h11, 1'b1);
        send(1, 8'h20, 1'b1); send(1, 8'h21, 1'b1);
        sb.delete();
        sb.push_back('{0, 8'h10}); sb.push_back('{1, 8'h20});
        sb.push_back('{0, 8'h11}); sb.push_back('{1, 8'h21});
        wait_drain("contention", 200);
    endtask

    task automatic test_packet_lock();
        bit got = 0;
        apply_reset();
        @(posedge clk); #1;
        send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b0);
        send(1, 8'hB0, 1'b1);
        sb.delete();
        sb.push_back('{0, 8'hA0}); sb.push_back('{0, 8'hA1});
        sb.push_back('{0, 8'hA2}); sb.push_back('{1, 8'hB0});
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk); #1;
            if (src_q[0].size() == 0 && !active[0] && !busy) got = 1;
        end
        repeat (20) @(posedge clk);
        #1;
        checks += 2;
        if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant: grant=%b, required 01", grant); end
        if (sb.size() != 2)  begin errors++; $display("FAIL lock_pending: %0d left, required 2", sb.size()); end
        src_q[0].push_back('{8'hA2, 1'b1});
        wait_drain("lock", 200);
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        @(posedge clk); #1;
        uart_stuck = 1;
        n = start_t.size();
        send(0, 8'h71, 1'b1); send(0, 8'h72, 1'b1);
        wait_drain("timeout", 100);
        uart_stuck = 0;
        checks++;
        if (start_t.size() < n + 2) begin
            errors++;
            $display("FAIL timeout_count: %0d starts, required 2", start_t.size() - n);
        end else if (start_t[n+1] - start_t[n] != LWM + 2) begin
            errors++;
            $display("FAIL timeout_spacing: %0d cycles, required %0d", start_t[n+1] - start_t[n], LWM + 2);
        end
    endtask

    task automatic test_ready_low();
        bit bad = 0;
        apply_reset();
        @(posedge clk); #1;
        uart_force_low = 1;
        repeat (2) @(posedge clk);
        #1 send(1, 8'h5A, 1'b1);
        repeat (10) begin
            @(posedge clk); #1;
            if (tx_start_trans !== 1'b0 || req_ready !== '0) bad = 1;
        end
        checks++;
        if (bad || sb.size() != 1) begin
            errors++;
            $display("FAIL ready_low_hold: launched while tx_ready low (pending=%0d), required none", sb.size());
        end
        uart_force_low = 0;
        wait_drain("ready_low", 60);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(posedge clk); #1;
        send(0, 8'h50, 1'b1);
        wait_drain("mid_pre", 60);
        send(0, 8'h51, 1'b1);
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_buff, tx_start_trans, req_ready, grant, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: buff=%h start=%b rdy=%b grant=%b busy=%b, required all 0",
                     tx_buff, tx_start_trans, req_ready, grant, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1, 8'h66, 1'b1);
        src_q[0].push_back('{8'h55, 1'b1});
        sb.delete();
        sb.push_back('{0, 8'h55}); sb.push_back('{1, 8'h66});
        wait_drain("mid_post", 100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_timeout();
        test_ready_low();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
